// File: rtl/bram_fifo_p_if.sv
// Push/pop bus of bram_fifo_p: write side with full/watermark backpressure,
// read side with fixed 2-clock read latency, plus occupancy and sticky error flags.
interface bram_fifo_p_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  push;
    logic [FIFO_WIDTH-1:0] push_data;
    logic                  full;
    logic                  almost_full;
    logic                  pop;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output push, push_data, pop,
        input  full, almost_full, rd_data, empty, count, overflow_err, underflow_err
    );

    modport slave (
        input  push, push_data, pop,
        output full, almost_full, rd_data, empty, count, overflow_err, underflow_err
    );
endinterface

// File: rtl/bram_fifo_p.sv
// Single-clock FIFO on an inferred block RAM; read data arrives 2 clocks after
// an accepted pop (registered RAM output followed by an output register).
module bram_fifo_p #(
    parameter int FIFO_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WATERMARK  = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    bram_fifo_p_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0]     ptr_t;
    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [FIFO_WIDTH-1:0]   data_t;

    data_t mem [DEPTH];

    ptr_t  wr_ptr_q,  wr_ptr_d;
    ptr_t  rd_ptr_q,  rd_ptr_d;
    addr_t rd_addr_q, rd_addr_d;
    logic  rd_v1_q,   rd_v1_d;
    logic  rd_v2_q,   rd_v2_d;
    data_t ram_q,     ram_d;
    data_t rd_data_q, rd_data_d;
    logic  ovf_q,     ovf_d;
    logic  unf_q,     unf_d;

    ptr_t  count;
    logic  empty;
    logic  full;
    logic  push_ok;
    logic  pop_ok;

    // Flags are decoded from the pointer registers, so they follow the edge after an accepted op.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign push_ok = bus.push && !full;
    assign pop_ok  = bus.pop && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ptr_t'(push_ok);
        rd_ptr_d  = rd_ptr_q + ptr_t'(pop_ok);
        rd_addr_d = pop_ok ? rd_ptr_q[ADDR_WIDTH-1:0] : rd_addr_q;
        // rd_v1/rd_v2 track a pop through the two read stages so rd_data only moves for real pops.
        rd_v1_d   = pop_ok;
        rd_v2_d   = rd_v1_q;
        ram_d     = rd_v1_q ? mem[rd_addr_q] : ram_q;
        rd_data_d = rd_v2_q ? ram_q : rd_data_q;
        ovf_d     = ovf_q | (bus.push & full);
        unf_d     = unf_q | (bus.pop & empty);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_addr_q <= '0;
            rd_v1_q   <= 1'b0;
            rd_v2_q   <= 1'b0;
            ram_q     <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_addr_q <= rd_addr_d;
            rd_v1_q   <= rd_v1_d;
            rd_v2_q   <= rd_v2_d;
            ram_q     <= ram_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; stale contents are never
    // visible because only addresses behind wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.push_data;
        end
    end

    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = count;
    assign bus.almost_full   = (count >= ptr_t'(WATERMARK));
    assign bus.rd_data       = rd_data_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_bram_fifo_p.sv
// Directed bench for bram_fifo_p: a vector table for the basic push/pop/latency
// behaviour, then hand-written sequences for fill/drain, wrap, errors and reset.
module tb_bram_fifo_p;
    localparam int W  = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    bram_fifo_p_if #(.FIFO_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    bram_fifo_p #(.FIFO_WIDTH(W), .ADDR_WIDTH(AW), .WATERMARK(28)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic          push;
        logic [W-1:0]  data;
        logic          pop;
        logic [AW:0]   cnt;
        logic          emp;
        logic          ful;
        logic          af;
        logic          of;
        logic          uf;
        logic [W-1:0]  rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then sample 1 ns later.
    task automatic cyc(input logic p, input logic [W-1:0] d, input logic q);
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;
        rst_n         = 1'b0;

        // push, data, pop | count, empty, full, almost_full, overflow, underflow, rd_data
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001};
        vecs[4] = '{1'b1, 32'h1234_5678, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[5] = '{1'b1, 32'h0000_BEEF, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF};
        vecs[9] = '{1'b0, 32'h0,         1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF};

        // Reset state
        do_reset();
        cyc(1'b0, '0, 1'b0);
        check("reset_empty", bus.empty, 1);
        check("reset_full", bus.full, 0);
        check("reset_count", bus.count, 0);
        check("reset_af", bus.almost_full, 0);
        check("reset_rd", bus.rd_data, 0);
        check("reset_of", bus.overflow_err, 0);
        check("reset_uf", bus.underflow_err, 0);

        // Table: single push/pop latency, push+pop while empty, back-to-back order, hold
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].push, vecs[i].data, vecs[i].pop);
            check($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
            check($sformatf("vec%0d_empty", i), bus.empty, vecs[i].emp);
            check($sformatf("vec%0d_full", i), bus.full, vecs[i].ful);
            check($sformatf("vec%0d_af", i), bus.almost_full, vecs[i].af);
            check($sformatf("vec%0d_of", i), bus.overflow_err, vecs[i].of);
            check($sformatf("vec%0d_uf", i), bus.underflow_err, vecs[i].uf);
            check($sformatf("vec%0d_rd", i), bus.rd_data, vecs[i].rd);
        end

        // Pop while empty: error sets, no data pulse, read pointer unmoved
        do_reset();
        cyc(1'b0, '0, 1'b1);
        check("uf_flag", bus.underflow_err, 1);
        check("uf_count", bus.count, 0);
        check("uf_empty", bus.empty, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0);
            check($sformatf("uf_nopulse%0d", i), bus.rd_data, 0);
        end
        cyc(1'b1, 32'h0000_5555, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("uf_after_rd", bus.rd_data, 32'h0000_5555);

        // Fill to full, watermark, rejected 33rd push, then drain back-to-back
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, W'(k - 1), 1'b0);
            check($sformatf("fill%0d_count", k), bus.count, k);
            check($sformatf("fill%0d_af", k), bus.almost_full, (k >= 28));
            check($sformatf("fill%0d_full", k), bus.full, (k == 32));
        end
        cyc(1'b1, 32'h99, 1'b0);
        check("ovf_flag", bus.overflow_err, 1);
        check("ovf_count", bus.count, 32);
        check("ovf_full", bus.full, 1);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, '0, 1'b1);
            check($sformatf("drain%0d_rd", i), bus.rd_data, (i >= 2) ? W'(i - 2) : W'(0));
        end
        check("drain_empty", bus.empty, 1);
        check("drain_count", bus.count, 0);
        cyc(1'b0, '0, 1'b0);
        check("drain_rd30", bus.rd_data, 30);
        cyc(1'b0, '0, 1'b0);
        check("drain_rd31", bus.rd_data, 31);
        cyc(1'b0, '0, 1'b0);
        check("drain_hold", bus.rd_data, 31);

        // Push+pop while full: only the pop is taken
        do_reset();
        for (int k = 0; k < 32; k++) cyc(1'b1, W'(32'h100 + k), 1'b0);
        check("pf_of_before", bus.overflow_err, 0);
        cyc(1'b1, 32'h77, 1'b1);
        check("pf_count", bus.count, 31);
        check("pf_of", bus.overflow_err, 1);
        check("pf_full", bus.full, 0);
        check("pf_uf", bus.underflow_err, 0);
        for (int i = 0; i < 31; i++) begin
            cyc(1'b0, '0, 1'b1);
            if (i >= 1) check($sformatf("pf_rd%0d", i), bus.rd_data, W'(32'h100 + i - 1));
        end
        cyc(1'b0, '0, 1'b0);
        check("pf_rd_tail0", bus.rd_data, 32'h11E);
        cyc(1'b0, '0, 1'b0);
        check("pf_rd_tail1", bus.rd_data, 32'h11F);
        check("pf_empty", bus.empty, 1);

        // Reset with pops in flight: nothing stale may leak out
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b1, W'(32'hC0 + k), 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1);
            check($sformatf("mrst%0d_rd", i), bus.rd_data, 0);
            check($sformatf("mrst%0d_count", i), bus.count, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b0);
            check($sformatf("post_rst%0d_rd", i), bus.rd_data, 0);
            check($sformatf("post_rst%0d_empty", i), bus.empty, 1);
        end
        check("post_rst_uf", bus.underflow_err, 0);

        // Steady push+pop at count=16 long enough for the pointers to wrap 4+ times
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, W'(1000 + k), 1'b0);
        for (int j = 0; j < 140; j++) begin
            cyc(1'b1, W'(1016 + j), 1'b1);
            check($sformatf("ss%0d_count", j), bus.count, 16);
            check($sformatf("ss%0d_full", j), bus.full, 0);
            check($sformatf("ss%0d_empty", j), bus.empty, 0);
            if (j >= 2) check($sformatf("ss%0d_rd", j), bus.rd_data, W'(1000 + j - 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
